// File: rtl/seg7_pkg.sv
// Shared segment encodings and elaboration helpers for the seven-segment scan driver.
package seg7_pkg;

  // Active-low segment patterns, bit6 = a ... bit0 = g.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // 10**n, used to derive the largest value the digit count can show.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per clock, VALUE_W steps.
module bin2bcd_seq #(
  parameter int unsigned VALUE_W = 14,
  parameter int unsigned DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    bin,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0]  r_bin;
  logic [DIGITS*4-1:0] r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_run;
  logic [DIGITS*4-1:0] w_adj;
  logic [VALUE_W-1:0]  w_bin_next;

  // One conversion step; bcd carries the post-step accumulator so the final
  // step's result can be captured on the same edge that completes it.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    {bcd, w_bin_next} = {w_adj, r_bin} << 1;
  end

  assign done = r_run && (r_cnt == CNT_W'(1));

  // Shift register, accumulator and step counter; start wins over an in-flight step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= CNT_W'(VALUE_W);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bin <= w_bin_next;
      r_bcd <= bcd;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver: binary-to-BCD conversion, pending load buffer,
// overflow dash, leading-zero blanking and common-anode digit scanning.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned VALUE_W  = 14,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  output logic               busy,
  output logic [6:0]         a_to_g,
  output logic [DIGITS-1:0]  an
);

  localparam int unsigned BCD_W     = DIGITS * 4;
  localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W     = $clog2(SCAN_DIV);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  logic               r_busy;
  logic               r_pend_vld;
  logic [VALUE_W-1:0] r_pend;
  logic               r_ovf_next;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_disp;
  logic [PRE_W-1:0]   r_pre;
  logic [IDX_W-1:0]   r_idx;
  logic [DIGITS-1:0]  r_an;
  logic [6:0]         r_seg;

  logic               w_done;
  logic [BCD_W-1:0]   w_bcd;
  logic               w_start;
  logic [VALUE_W-1:0] w_next_val;
  logic               w_pre_tc;
  logic [PRE_W-1:0]   w_pre_next;
  logic [IDX_W-1:0]   w_idx_next;
  logic [31:0]        w_idx32;
  logic [BCD_W-1:0]   w_disp_next;
  logic               w_ovf_disp;
  logic [3:0]         w_nib;
  logic               w_upper_zero;
  logic [6:0]         w_seg_next;
  logic [DIGITS-1:0]  w_an_next;

  bin2bcd_seq #(
    .VALUE_W(VALUE_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .start(w_start),
    .bin  (w_next_val),
    .done (w_done),
    .bcd  (w_bcd)
  );

  // A load on the commit edge outranks any older pending value; either feeds
  // the converter directly so back-to-back conversions have no idle cycle.
  always_comb begin
    w_next_val = load ? value : r_pend;
    w_start    = (load && !r_busy) || (w_done && (load || r_pend_vld));
  end

  // Busy flag, pending buffer, overflow tracking and committed display value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      r_ovf_next <= 1'b0;
      r_ovf      <= 1'b0;
      r_disp     <= '0;
    end else begin
      if (w_done) begin
        r_disp <= w_bcd;
        r_ovf  <= r_ovf_next;
      end
      if (w_start) begin
        r_busy     <= 1'b1;
        r_ovf_next <= (64'(w_next_val) >= OVF_LIMIT);
      end else if (w_done) begin
        r_busy <= 1'b0;
      end
      if (w_done) begin
        r_pend_vld <= 1'b0;
      end else if (load && r_busy) begin
        r_pend     <= value;
        r_pend_vld <= 1'b1;
      end
    end
  end

  // Outputs are decoded from next-state index/display so an and a_to_g
  // switch on the same edge as the index or commit that changes them.
  always_comb begin
    w_pre_tc   = (r_pre == PRE_W'(SCAN_DIV - 1));
    w_pre_next = w_pre_tc ? '0 : r_pre + PRE_W'(1);
    w_idx_next = r_idx;
    if (w_pre_tc) begin
      w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
    w_idx32     = 32'(w_idx_next);
    w_disp_next = w_done ? w_bcd : r_disp;
    w_ovf_disp  = w_done ? r_ovf_next : r_ovf;

    w_nib        = '0;
    w_upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i == w_idx32) begin
        w_nib = w_disp_next[4*i +: 4];
      end
      if (i >= w_idx32 && w_disp_next[4*i +: 4] != 4'd0) begin
        w_upper_zero = 1'b0;
      end
    end

    if (w_ovf_disp) begin
      w_seg_next = SEG_DASH;
    end else if (blank_lz && w_idx32 != 32'd0 && w_upper_zero) begin
      w_seg_next = SEG_BLANK;
    end else if (w_nib < 4'd10) begin
      w_seg_next = SEG_DIGIT[w_nib];
    end else begin
      w_seg_next = SEG_BLANK;
    end

    w_an_next = ~(DIGITS'(1) << w_idx_next);
  end

  // Prescaler, scan index and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= ~DIGITS'(1);
      r_seg <= SEG_DIGIT[0];
    end else begin
      r_pre <= w_pre_next;
      r_idx <= w_idx_next;
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign busy   = r_busy;
  assign a_to_g = r_seg;
  assign an     = r_an;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed self-checking bench for seg7_scan_display (DIGITS=4, VALUE_W=14, SCAN_DIV=4).
module tb_seg7_scan_display;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned VALUE_W  = 14;
  localparam int unsigned SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [VALUE_W-1:0] value = '0;
  logic               load = 1'b0;
  logic               blank_lz = 1'b0;
  logic               busy;
  logic [6:0]         a_to_g;
  logic [DIGITS-1:0]  an;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_display #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .load    (load),
    .blank_lz(blank_lz),
    .busy    (busy),
    .a_to_g  (a_to_g),
    .an      (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until digit d is active, then check its segments.
  task automatic read_digit(input string tag, input int d, input logic [6:0] exp);
    logic [3:0] mask;
    int n;
    mask = ~(4'b0001 << d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== mask && n < 20);
    check({tag, "_an"}, 32'(an), 32'(mask));
    check(tag, 32'(a_to_g), 32'(exp));
  endtask

  task automatic read_all(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                          input logic [6:0] e2, input logic [6:0] e3);
    read_digit({tag, "_d0"}, 0, e0);
    read_digit({tag, "_d1"}, 1, e1);
    read_digit({tag, "_d2"}, 2, e2);
    read_digit({tag, "_d3"}, 3, e3);
  endtask

  // Check whichever digit is currently active against the expected pattern.
  task automatic check_active(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e;
    case (an)
      4'b1110: e = e0;
      4'b1101: e = e1;
      4'b1011: e = e2;
      4'b0111: e = e3;
      default: e = 7'bxxxxxxx;
    endcase
    check(tag, 32'(a_to_g), 32'(e));
  endtask

  task automatic do_load(input logic [VALUE_W-1:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int cnt;
    logic [3:0] exp_an;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_an", 32'(an), 32'(4'b1110));
    check("rst_seg", 32'(a_to_g), 32'(S0));
    rst_n = 1'b1;

    // Scan sequence: digit changes every SCAN_DIV edges
    for (int p = 0; p <= 16; p++) begin
      if (p > 0) @(negedge clk);
      exp_an = ~(4'b0001 << ((p / 4) % 4));
      check("scan_an", 32'(an), 32'(exp_an));
    end
    read_all("zero", S0, S0, S0, S0);
    blank_lz = 1'b1;
    read_all("zero_blank", S0, SB, SB, SB);
    blank_lz = 1'b0;

    // Single conversion of 13, busy for exactly VALUE_W cycles
    do_load(14'd13);
    check("v13_busy_rise", 32'(busy), 32'(1));
    cnt = 1;
    while (busy && cnt < 100) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("v13_busy_len", 32'(cnt), 32'(14));
    read_all("v13", S3, S1, S0, S0);
    blank_lz = 1'b1;
    read_all("v13_blank", S3, S1, SB, SB);
    blank_lz = 1'b0;

    // Largest representable value, then first overflowing value
    do_load(14'd9999);
    wait_idle("v9999");
    read_all("v9999", S9, S9, S9, S9);
    do_load(14'd10000);
    wait_idle("v10000");
    read_all("v10000", SD, SD, SD, SD);
    blank_lz = 1'b1;
    read_digit("v10000_blank_d3", 3, SD);
    blank_lz = 1'b0;

    // 42, then 7 and 5 while busy: 5 overwrites 7 in the pending buffer
    for (int k = 0; k < 32; k++) begin
      load  = (k == 0 || k == 2 || k == 3);
      value = (k == 0) ? 14'd42 : (k == 2) ? 14'd7 : 14'd5;
      @(negedge clk);
      load = 1'b0;
      check("pend_busy", 32'(busy), 32'(k < 28));
      if (k < 14)      check_active("pend_old", SD, SD, SD, SD);
      else if (k < 28) check_active("pend_42", S2, S4, S0, S0);
      else             check_active("pend_5", S5, S0, S0, S0);
    end

    // Load on the commit edge with an empty pending buffer
    for (int k = 0; k < 32; k++) begin
      load  = (k == 0 || k == 14);
      value = (k == 0) ? 14'd100 : 14'd321;
      @(negedge clk);
      load = 1'b0;
      check("coinc_busy", 32'(busy), 32'(k < 28));
      if (k < 14)      check_active("coinc_old", S5, S0, S0, S0);
      else if (k < 28) check_active("coinc_100", S0, S0, S1, S0);
      else             check_active("coinc_321", S1, S2, S3, S0);
    end

    // Reset during step 6 of a conversion
    do_load(14'd777);
    repeat (6) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_an", 32'(an), 32'(4'b1110));
    check("mid_rst_seg", 32'(a_to_g), 32'(S0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'(0));
    read_all("post_rst", S0, S0, S0, S0);
    do_load(14'd1234);
    wait_idle("v1234");
    read_all("v1234", S4, S3, S2, S1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
